// File: rtl/mem_image_loader.sv
// Boot-time image loader: streams 32-bit words into byte-wide memory, optional zero fill, holds CPU in reset until done.
// Define LOADER_CHECKSUM_EN to add the o_checksum port (mod 2**32 sum of accepted words).
module mem_image_loader #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int FILL_ZERO = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_in_data,
    input  logic              i_in_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_done,
    output logic              o_overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       o_checksum,
`endif
    output logic [ADDR_W-1:0] o_word_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic              r_held;
    logic              r_first;
    logic              r_last;
    logic [1:0]        r_byte;
    logic [23:0]       r_shift;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       r_checksum;
`endif

    logic              w_at_end;
    logic              w_in_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_next_addr;

    // Overflow is detected on the last address before any increment, so the address never wraps.
    assign w_at_end    = (r_mem_addr == LAST_ADDR);
    assign w_in_ready  = (r_state == ST_LOAD) &&
                         (!r_held || ((r_byte == 2'd3) && !r_last && !w_at_end));
    assign w_accept    = w_in_ready && i_in_valid;
    assign w_next_addr = r_first ? '0 : r_mem_addr + ADDR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_held       <= 1'b0;
            r_first      <= 1'b1;
            r_last       <= 1'b0;
            r_byte       <= '0;
            r_shift      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_held       <= 1'b1;
                        r_first      <= 1'b0;
                        r_last       <= i_in_last;
                        r_byte       <= '0;
                        r_shift      <= i_in_data[31:8];
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= w_next_addr;
                        r_mem_wdata  <= i_in_data[7:0];
                        r_word_count <= r_word_count + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        r_checksum   <= r_checksum + i_in_data;
`endif
                    end else if (r_held && (r_byte != 2'd3)) begin
                        r_byte      <= r_byte + 2'd1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata <= r_shift[7:0];
                        r_shift     <= {8'h00, r_shift[23:8]};
                    end else if (r_held) begin
                        if (r_last && (FILL_ZERO != 0) && !w_at_end) begin
                            r_state     <= ST_FILL;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                            r_mem_wdata <= '0;
                        end else if (r_last || w_at_end) begin
                            r_state     <= ST_DONE;
                            r_held      <= 1'b0;
                            r_mem_we    <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                            r_overflow  <= !r_last;
                        end else begin
                            r_held   <= 1'b0;
                            r_mem_we <= 1'b0;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_at_end) begin
                        r_state     <= ST_DONE;
                        r_held      <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both restart a load on Start.
                    if (i_start) begin
                        r_state      <= ST_LOAD;
                        r_held       <= 1'b0;
                        r_first      <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_cpu_reset  <= 1'b1;
                        r_done       <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum   <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_word_count = r_word_count;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum   = r_checksum;
`endif

endmodule
